// File: rtl/lnvd_dac_pkg.sv
// Shared types and constants for the lnvd DAC output sequencer.
package lnvd_dac_pkg;

    // Sequencer states: one channel write is SETUP -> STROBE -> HOLD,
    // repeated for every channel, then a single LOAD pulse.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_LOAD   = 3'd4
    } state_t;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int OVR_W   = 8;
    localparam int TIMER_W = 16;

    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [OVR_W-1:0] OVR_SAT = {OVR_W{1'b1}};

    typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/lnvd_phase_timer.sv
// Loadable down-counter that times how long the sequencer stays in a state.
// A load of N makes done rise on the N-th cycle after the load edge.
module lnvd_phase_timer
    import lnvd_dac_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Reload on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count: the last cycle of the current phase.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/lnvd_dac_mux.sv
// Four-channel frame sequencer onto a shared parallel DAC bus.
// Each channel is written with setup / write-strobe / hold timing, and a final
// LDAC pulse updates all four DAC outputs at once.
// Optional build macro: LNVD_DAC_OFFSET_BIN_EN inverts each sample MSB at
// latch time (two's-complement to offset binary).
//
// Input handshake: a frame transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is high only in IDLE. in_valid while in_ready
// is low drops that cycle's frame and bumps the saturating overrun_cnt; the
// frame already in flight is never touched by new input.
module lnvd_dac_mux
    import lnvd_dac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic [DATA_W-1:0] in_data4,
    output logic [DATA_W-1:0] dac_data,
    output logic [1:0]        dac_sel,
    output logic              dac_wr_n,
    output logic              dac_ldac_n,
    output logic              busy,
    output logic [7:0]        overrun_cnt,
    output state_t            dbg_state
);

    state_t            state;
    ch_t               ch;
    ch_t               ch_next;
    logic [DATA_W-1:0] frame [NUM_CH];
    logic              accept;
    logic              tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic              tmr_done;

    // Sample conversion applied once, when the frame is latched.
    function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] s);
`ifdef LNVD_DAC_OFFSET_BIN_EN
        return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
        return s;
`endif
    endfunction

    assign accept    = in_valid && in_ready;
    assign ch_next   = ch + 1'b1;
    assign dbg_state = state;

    // Phase length for the state being entered; load fires on every entry.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(STROBE_CYC);
                end
            end
            S_STROBE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = (ch == LAST_CH) ? TIMER_W'(1) : TIMER_W'(SETUP_CYC);
                end
            end
            S_LOAD: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    lnvd_phase_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Sequencer FSM with registered bus outputs and overrun counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ch          <= '0;
            for (int i = 0; i < NUM_CH; i++) frame[i] <= '0;
            dac_data    <= '0;
            dac_sel     <= '0;
            dac_wr_n    <= 1'b1;
            dac_ldac_n  <= 1'b1;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && overrun_cnt != OVR_SAT) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    in_ready   <= 1'b1;
                    busy       <= 1'b0;
                    dac_ldac_n <= 1'b1;
                    if (accept) begin
                        frame[0] <= conv(in_data1);
                        frame[1] <= conv(in_data2);
                        frame[2] <= conv(in_data3);
                        frame[3] <= conv(in_data4);
                        ch       <= '0;
                        dac_data <= conv(in_data1);
                        dac_sel  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tmr_done) begin
                        dac_wr_n <= 1'b0;
                        state    <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (tmr_done) begin
                        dac_wr_n <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (tmr_done) begin
                        if (ch == LAST_CH) begin
                            dac_ldac_n <= 1'b0;
                            state      <= S_LOAD;
                        end else begin
                            ch       <= ch_next;
                            dac_data <= frame[ch_next];
                            dac_sel  <= ch_next;
                            state    <= S_SETUP;
                        end
                    end
                end
                S_LOAD: begin
                    if (tmr_done) begin
                        dac_ldac_n <= 1'b1;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
